music_sequencer: RTL



---
 rtl/music_seq_pkg.sv | 20 ++
 rtl/music_seq_timer.sv | 59 +++++
 rtl/music_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/music_seq_pkg.sv
// Shared types and constants for the note sequencer: note-table entry layout,
// sequencer state encoding and a few named pitch codes for audio_channel.
package music_seq_pkg;
  localparam int FREQ_W  = 16;
  localparam int DUR_W   = 4;
  localparam int ENTRY_W = 2 + DUR_W + FREQ_W;

  typedef struct packed {
    logic              last;
    logic              rest;
    logic [DUR_W-1:0]  dur;
    logic [FREQ_W-1:0] freq;
  } note_entry_t;

  typedef enum logic {IDLE, PLAY} seq_state_t;

  localparam logic [FREQ_W-1:0] G4_FREQ  = 16'd4208;
  localparam logic [FREQ_W-1:0] DD4_FREQ = 16'd3339;
  localparam logic [FREQ_W-1:0] AD4_FREQ = 16'd5005;
endpackage

// File: rtl/music_seq_timer.sv
// Tick/step tempo counters for one note-table entry.
// MUSIC_SEQUENCER_GAP_EN enables the end-of-note release window flag.
module music_seq_timer
  import music_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 3125000,
  parameter int GAP_CYCLES  = 125000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [DUR_W-1:0] dur_i,
  output logic             note_end_o,
  output logic             gap_active_o
);
  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_START = TW'(STEP_CYCLES - GAP_CYCLES);
`ifdef MUSIC_SEQUENCER_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic [TW-1:0]    tick_q, tick_d;
  logic [DUR_W-1:0] step_q, step_d;
  logic             tick_end, last_step;

  assign tick_end  = (tick_q == TICK_LAST);
  assign last_step = (step_q == dur_i);

  always_comb begin
    tick_d = tick_q + 1'b1;
    step_d = step_q;
    if (clear_i || !run_i) begin
      tick_d = '0;
      step_d = '0;
    end else if (tick_end) begin
      tick_d = '0;
      step_d = step_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_q <= '0;
      step_q <= '0;
    end else begin
      tick_q <= tick_d;
      step_q <= step_d;
    end
  end

  assign note_end_o   = run_i && tick_end && last_step;
  // Release window covers the last GAP_CYCLES ticks of the final step.
  assign gap_active_o = GAP_EN && (GAP_CYCLES > 0) && run_i && last_step &&
                        (tick_q >= GAP_START);
endmodule

// File: rtl/music_sequencer.sv
// Note sequencer feeding audio_channel en_i/freq_i from a programmable note table.
// Optional MUSIC_SEQUENCER_GAP_EN: release gap at the end of each sounding note.
module music_sequencer
  import music_seq_pkg::*;
#(
  parameter int SONG_LEN    = 16,
  parameter int STEP_CYCLES = 3125000,
  parameter int GAP_CYCLES  = 125000,
  localparam int AW = $clog2(SONG_LEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               loop_i,
  output logic               en_o,
  output logic [FREQ_W-1:0]  freq_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [AW-1:0]      idx_o
);
  note_entry_t mem_q [SONG_LEN];

  seq_state_t        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d, apply_idx;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              en_q, en_d, done_q, done_d, last_q, last_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              apply, note_end, gap_active;
  note_entry_t       fetch;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= note_entry_t'(wr_data_i);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    freq_d    = freq_q;
    en_d      = en_q;
    done_d    = 1'b0;
    dur_d     = dur_q;
    last_d    = last_q;
    apply     = 1'b0;
    apply_idx = '0;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_d = PLAY;
          apply   = 1'b1;
        end
      end
      PLAY: begin
        if (stop_i) begin
          state_d = IDLE;
          en_d    = 1'b0;
          idx_d   = '0;
        end else if (note_end) begin
          if (!last_q && idx_q != AW'(SONG_LEN - 1)) begin
            apply     = 1'b1;
            apply_idx = idx_q + 1'b1;
          end else if (loop_i) begin
            apply = 1'b1;
          end else begin
            state_d = IDLE;
            en_d    = 1'b0;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The playing entry is latched here, so later table writes only affect re-fetches.
    fetch = mem_q[apply_idx];
    if (apply) begin
      idx_d  = apply_idx;
      dur_d  = fetch.dur;
      last_d = fetch.last;
      en_d   = !fetch.rest;
      if (!fetch.rest) freq_d = fetch.freq;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      freq_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      dur_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      freq_q  <= freq_d;
      en_q    <= en_d;
      done_q  <= done_d;
      dur_q   <= dur_d;
      last_q  <= last_d;
    end
  end

  music_seq_timer #(
    .STEP_CYCLES(STEP_CYCLES),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (apply),
    .run_i       (state_q == PLAY),
    .dur_i       (dur_q),
    .note_end_o  (note_end),
    .gap_active_o(gap_active)
  );

  assign en_o   = en_q & ~gap_active;
  assign freq_o = freq_q;
  assign busy_o = (state_q == PLAY);
  assign done_o = done_q;
  assign idx_o  = idx_q;
endmodule
